// File: rtl/fetch_unit.sv
// fetch_unit: PC register, ROM address drive and 2-entry prefetch queue with redirect/halt.
// Optional FETCH_PERF_CNT_EN adds fetch_count/stall_count outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [31:0]           rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   input  logic                  halt,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_instr,
   output logic [31:0]           out_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]           fetch_count,
   output logic [31:0]           stall_count
`endif
);
   typedef enum logic {RUN, HALT} state_t;
   state_t state;
   logic [31:0] fetch_pc;
   logic [1:0] count;
   logic [1:0] level;
   logic [31:0] q_pc [2];
   logic [DATA_WIDTH-1:0] q_instr [2];
   logic pop, push;
   assign rom_addr = fetch_pc;
   assign out_valid = count != 2'd0;
   assign out_pc = q_pc[0];
   assign out_instr = q_instr[0];
   assign pop = out_valid & out_ready;
   assign push = (state == RUN) & !halt & !redirect_valid & ((count != 2'd2) | pop);
   // occupancy after the pop; also the slot a push lands in
   assign level = count - {1'b0, pop};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         fetch_pc <= RESET_PC;
         count <= 2'd0;
         q_pc <= '{default: '0};
         q_instr <= '{default: '0};
      end else if (redirect_valid) begin
         state <= RUN;
         fetch_pc <= redirect_pc;
         count <= 2'd0;
      end else begin
         state <= halt ? HALT : RUN;
         if (pop) begin
            q_pc[0] <= q_pc[1];
            q_instr[0] <= q_instr[1];
         end
         if (push) begin
            q_pc[level[0]] <= fetch_pc;
            q_instr[level[0]] <= rom_data;
            fetch_pc <= fetch_pc + 32'd1;
         end
         count <= level + {1'b0, push};
      end
   end
`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count <= 32'd0;
         stall_count <= 32'd0;
      end else begin
         fetch_count <= fetch_count + {31'd0, push};
         stall_count <= stall_count + {31'd0, out_valid & !out_ready};
      end
   end
`endif
endmodule
